// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline-stage register with a valid/ready handshake.
// It holds a main entry and a one-entry skid buffer, so o_ready comes
// straight from a flop. A synchronous flush drops every held beat, and a
// saturating counter records the cycles the downstream side stalls.
module pipe_reg_elastic #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    typedef enum logic [1:0] {
        StEmpty,
        StFull,
        StSkid
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e            state;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [DATA_W-1:0] s_data;
    logic              s_free;
    logic [CNT_W-1:0]  stall_cnt;

    logic in_fire;
    logic out_fire;

    // The handshakes use only registered ready/valid, so no input reaches an output.
    assign in_fire  = i_valid & s_free;
    assign out_fire = m_valid & i_ready;

    // Occupancy FSM. The data registers are cleared whenever their entry is empty.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= StEmpty;
            m_valid <= 1'b0;
            m_data  <= '0;
            s_data  <= '0;
            s_free  <= 1'b1;
        end else if (i_flush) begin
            state   <= StEmpty;
            m_valid <= 1'b0;
            m_data  <= '0;
            s_data  <= '0;
            s_free  <= 1'b1;
        end else begin
            unique case (state)
                StEmpty: begin
                    if (in_fire) begin
                        state   <= StFull;
                        m_valid <= 1'b1;
                        m_data  <= i_data;
                    end
                end
                StFull: begin
                    if (in_fire && out_fire) begin
                        m_data <= i_data;
                    end else if (out_fire) begin
                        state   <= StEmpty;
                        m_valid <= 1'b0;
                        m_data  <= '0;
                    end else if (in_fire) begin
                        // Downstream is stalled, so park the new beat in the skid entry.
                        state  <= StSkid;
                        s_data <= i_data;
                        s_free <= 1'b0;
                    end
                end
                StSkid: begin
                    if (out_fire) begin
                        state  <= StFull;
                        m_data <= s_data;
                        s_data <= '0;
                        s_free <= 1'b1;
                    end
                end
                default: begin
                    state   <= StEmpty;
                    m_valid <= 1'b0;
                    m_data  <= '0;
                    s_data  <= '0;
                    s_free  <= 1'b1;
                end
            endcase
        end
    end

    // Count back-pressured cycles, including a flush cycle. Only reset clears it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_cnt <= '0;
        end else if (m_valid && !i_ready && (stall_cnt != CntMax)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign o_valid     = m_valid;
    assign o_data      = m_data;
    assign o_ready     = s_free;
    assign o_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Bench for pipe_reg_elastic. dut0 uses the default widths and runs the
// directed sequences. dut1 (7-bit data, 4-bit counter) runs the saturation
// case. dut1 and dut96 then run randomised traffic against a queue model.
module tb_pipe_reg_elastic;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // dut0: DATA_W=32, CNT_W=16
    logic        flush0, valid0, rdy_dn0;
    logic [31:0] data0;
    logic        ordy0, ov0;
    logic [31:0] od0;
    logic [15:0] cnt0;

    // dut1: DATA_W=7, CNT_W=4
    logic        flush1, valid1, rdy_dn1;
    logic [6:0]  data1;
    logic        ordy1, ov1;
    logic [6:0]  od1;
    logic [3:0]  cnt1;

    // dut96: DATA_W=96, CNT_W=16
    logic        flush2, valid2, rdy_dn2;
    logic [95:0] data2;
    logic        ordy2, ov2;
    logic [95:0] od2;
    logic [15:0] cnt2;

    pipe_reg_elastic #(.DATA_W(32), .CNT_W(16)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_flush(flush0), .i_valid(valid0), .o_ready(ordy0),
        .i_data(data0), .o_valid(ov0), .i_ready(rdy_dn0), .o_data(od0), .o_stall_cnt(cnt0)
    );

    pipe_reg_elastic #(.DATA_W(7), .CNT_W(4)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_flush(flush1), .i_valid(valid1), .o_ready(ordy1),
        .i_data(data1), .o_valid(ov1), .i_ready(rdy_dn1), .o_data(od1), .o_stall_cnt(cnt1)
    );

    pipe_reg_elastic #(.DATA_W(96), .CNT_W(16)) dut96 (
        .i_clk(clk), .i_reset(rst), .i_flush(flush2), .i_valid(valid2), .o_ready(ordy2),
        .i_data(data2), .o_valid(ov2), .i_ready(rdy_dn2), .o_data(od2), .o_stall_cnt(cnt2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue models for the random phase
    int          occ1, occ2;
    logic [95:0] q1 [2];
    logic [95:0] q2 [2];
    logic        inf, outf;

    initial begin
        rst = 1'b1;
        flush0 = 0; valid0 = 1; rdy_dn0 = 1; data0 = 32'hDEADBEEF;
        flush1 = 0; valid1 = 0; rdy_dn1 = 1; data1 = '0;
        flush2 = 0; valid2 = 0; rdy_dn2 = 1; data2 = '0;

        // Reset held for two cycles with a valid beat presented
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_valid", ov0, 0);
            check("rst_data", od0, 0);
            check("rst_ready", ordy0, 1);
            check("rst_cnt", cnt0, 0);
        end
        rst = 1'b0;
        tick();
        check("first_valid", ov0, 1);
        check("first_data", od0, 32'hDEADBEEF);

        // Streaming 1..16 with downstream always ready
        for (int k = 1; k <= 16; k++) begin
            data0 = k;
            tick();
            check("stream_data", od0, k);
            check("stream_valid", ov0, 1);
            check("stream_ready", ordy0, 1);
        end
        valid0 = 0;
        tick();
        check("stream_drain_valid", ov0, 0);
        check("stream_drain_data", od0, 0);
        check("stream_cnt", cnt0, 0);

        // Back-pressure and skid
        valid0 = 1; data0 = 32'hA; rdy_dn0 = 1;
        tick();
        check("bp_a_out", od0, 32'hA);
        data0 = 32'hB; rdy_dn0 = 0;
        tick();
        check("bp_hold_a1", od0, 32'hA);
        check("bp_ready_drop", ordy0, 0);
        data0 = 32'hC;
        tick();
        check("bp_hold_a2", od0, 32'hA);
        tick();
        check("bp_hold_a3", od0, 32'hA);
        check("bp_cnt3", cnt0, 3);
        rdy_dn0 = 1;
        tick();
        check("bp_out_b", od0, 32'hB);
        check("bp_ready_back", ordy0, 1);
        tick();
        check("bp_out_c", od0, 32'hC);
        valid0 = 0;
        tick();
        check("bp_empty", ov0, 0);
        check("bp_cnt_keep", cnt0, 3);

        // Flush while in SKID holding 0x11 and 0x22
        valid0 = 1; data0 = 32'h11; rdy_dn0 = 1;
        tick();
        data0 = 32'h22; rdy_dn0 = 0;
        tick();
        check("fl_skid_ready", ordy0, 0);
        check("fl_skid_cnt", cnt0, 4);
        flush0 = 1; data0 = 32'h33;
        tick();
        check("fl_valid", ov0, 0);
        check("fl_data", od0, 0);
        check("fl_ready", ordy0, 1);
        check("fl_cnt", cnt0, 5);
        flush0 = 0; valid0 = 0; rdy_dn0 = 1;
        tick();
        check("fl_no_33_valid", ov0, 0);
        check("fl_no_33_data", od0, 0);

        // Saturation on the 4-bit counter
        valid1 = 1; data1 = 7'h5; rdy_dn1 = 1;
        tick();
        valid1 = 0; rdy_dn1 = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) check("sat_14", cnt1, 14);
            if (i == 15) check("sat_15", cnt1, 15);
        end
        check("sat_hold", cnt1, 15);
        check("sat_data", od1, 7'h5);
        flush1 = 1;
        tick();
        flush1 = 0;
        check("sat_flush_empty", ov1, 0);
        check("sat_after_flush", cnt1, 15);

        // Random traffic on dut1 and dut96 against queue models
        occ1 = 0; occ2 = 0;
        q1[0] = '0; q1[1] = '0; q2[0] = '0; q2[1] = '0;
        for (int c = 0; c < 400; c++) begin
            valid1  = 1'($urandom_range(0, 1));
            rdy_dn1 = 1'($urandom_range(0, 1));
            flush1  = ($urandom_range(0, 15) == 0);
            data1   = 7'($urandom_range(0, 127));
            valid2  = 1'($urandom_range(0, 1));
            rdy_dn2 = 1'($urandom_range(0, 1));
            flush2  = ($urandom_range(0, 15) == 0);
            data2   = {$urandom, $urandom, $urandom};

            if (flush1) begin
                occ1 = 0; q1[0] = '0; q1[1] = '0;
            end else begin
                inf  = valid1 && (occ1 < 2);
                outf = (occ1 > 0) && rdy_dn1;
                if (outf) begin
                    q1[0] = q1[1]; q1[1] = '0; occ1--;
                end
                if (inf) begin
                    q1[occ1] = {89'b0, data1}; occ1++;
                end
            end
            if (flush2) begin
                occ2 = 0; q2[0] = '0; q2[1] = '0;
            end else begin
                inf  = valid2 && (occ2 < 2);
                outf = (occ2 > 0) && rdy_dn2;
                if (outf) begin
                    q2[0] = q2[1]; q2[1] = '0; occ2--;
                end
                if (inf) begin
                    q2[occ2] = data2; occ2++;
                end
            end

            tick();
            check("r7_valid", ov1, occ1 > 0);
            check("r7_data", od1, (occ1 > 0) ? q1[0] : 96'b0);
            check("r7_ready", ordy1, occ1 < 2);
            check("r96_valid", ov2, occ2 > 0);
            check("r96_data", od2, (occ2 > 0) ? q2[0] : 96'b0);
            check("r96_ready", ordy2, occ2 < 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_reg_elastic.md
# pipe_reg_elastic

Parametrised elastic pipeline-stage register, the successor to the fixed per-signal inter-stage flip-flop banks of the pipelined core. It carries an arbitrary-width packed stage payload with a valid/ready handshake, a one-entry skid buffer so the upstream ready is fully registered, and a synchronous flush for branch redirect. A saturating stall counter feeds performance monitoring. One instance sits between each pair of pipeline stages.

## Interface
- DATA_W, 32, payload width in bits (pc, pc+4, control fields and operands packed by the instantiating stage); legal 1..512
- CNT_W, 16, stall-counter width; legal 1..32
- One clock; reset is synchronous and active-high.
- i_clk  in  1  clock; all state updates on the rising edge
- i_reset  in  1  synchronous active-high reset
- i_flush  in  1  synchronous kill of all held entries (pc_sel redirect)
- i_valid  in  1  upstream payload valid
- o_ready  out  1  stage can accept; registered, equals "skid entry empty"
- i_data  in  DATA_W  upstream payload
- o_valid  out  1  downstream payload valid
- i_ready  in  1  downstream accepts
- o_data  out  DATA_W  downstream payload; all-zero whenever o_valid=0
- o_stall_cnt  out  CNT_W  saturating count of back-pressured cycles

## Operation
- Storage: main entry M (valid, data) drives o_valid/o_data; skid entry S (valid, data) holds at most one extra beat.
- Fire definitions: in_fire = i_valid & o_ready; out_fire = o_valid & i_ready.
- States:
  - EMPTY: M.v=0, S.v=0.
  - FULL: M.v=1, S.v=0.
  - SKID: M.v=1, S.v=1.
- EMPTY: in_fire -> FULL, M.data=i_data; otherwise stay.
- FULL:
  - in_fire & out_fire -> FULL, M.data=i_data.
  - out_fire only -> EMPTY, M.data=0.
  - in_fire only -> SKID, S.data=i_data.
  - neither -> hold.
- SKID: o_ready=0, so no in_fire. out_fire -> FULL, M.data=S.data, S.data=0; otherwise hold.
- Priority: i_reset > i_flush > handshake.
- Flush: next state EMPTY, M.data=S.data=0. A beat presented on the flush cycle is discarded even when in_fire=1. An out_fire on the flush cycle still counts as delivered downstream. o_ready=1 the following cycle.
- Ordering: strict FIFO, no beat lost, duplicated or reordered outside flush.
- Stall counter:
  - +1 each cycle o_valid & ~i_ready, including the flush cycle.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by reset, not by flush.
- Data bits are never interpreted; width arithmetic is none.

## Timing
- Reset values: o_valid=0, o_data=0, o_ready=1, o_stall_cnt=0; internal S.v=0, M.v=0.
- Reset mid-operation drops all held beats.
- Latency: 1 cycle. A beat accepted at edge N appears on o_valid/o_data after edge N when the stage was EMPTY, or FULL with out_fire.
- Throughput: 1 beat/cycle with i_ready held high.
- o_ready deasserts the cycle after the first un-drained in_fire (the SKID entry). It reasserts the cycle after the out_fire that drains S.
- Capacity: 2 beats. Upstream sees back-pressure one cycle late, absorbed by S.
- o_ready, o_valid, o_data and o_stall_cnt are register outputs with no combinational path from any input.

## Test plan
- Reset: hold i_reset=1 for 2 cycles with i_valid=1, i_data=0xDEADBEEF -> o_valid=0, o_data=0, o_ready=1, o_stall_cnt=0 throughout. First beat accepted on the first cycle after release.
- Streaming: i_ready=1, send 0x1,0x2,...,0x10 back-to-back -> o_data emits the same sequence one cycle delayed, o_ready stays 1, o_stall_cnt=0.
- Back-pressure/skid:
  - Send 0xA,0xB,0xC continuously; i_ready=0 for 3 cycles starting when 0xA is on o_data.
  - Required: 0xB lands in S, o_ready drops the next cycle, 0xC is held upstream, o_stall_cnt=3.
  - Release i_ready: output is exactly 0xA,0xB,0xC.
- Flush:
  - In SKID holding 0x11 (M) and 0x22 (S), assert i_flush with i_valid=1, i_data=0x33 and i_ready=0.
  - Next cycle: o_valid=0, o_data=0, o_ready=1, and 0x33 never appears.
  - o_stall_cnt retains its value incremented by 1 (the flush cycle).
- Saturation: CNT_W=4, hold o_valid=1 and i_ready=0 for 20 cycles -> o_stall_cnt reaches 15 and stays 15.
- Random: DATA_W=7 and DATA_W=96, random i_valid/i_ready/i_flush against a scoreboard -> no loss or duplication, o_data=0 whenever o_valid=0, occupancy never exceeds 2.
